// File: rtl/accumulator_64bit.sv
// ---------------------------------------------------------------------------
// accumulator_64bit
//
// Registered 64-bit accumulator. Each accepted command feeds the current
// accumulator value and the operand into one full_adder_64bit instance. The
// result is committed with optional signed saturation and is presented,
// together with its flags, through a single-entry valid/ready output stage.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     command valid
//   in_ready     command can be accepted this cycle
//   in_op        00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   in_data      64-bit operand
//   in_cin       carry-in for ADD (ignored for other ops)
//   sat_en       saturation enable, sampled on accept
//   sticky_clr   clears sticky_ovf (independent of accept)
//   acc_out      committed accumulator value
//   cout_flag    adder carry-out of the last accepted command
//   ovf_flag     adder signed overflow of the last accepted command
//   sat_flag     last committed result was saturated
//   sticky_ovf   overflow seen since last clear
//   op_count     accepted command count, wrapping
//   out_valid    result/flags valid
//   out_ready    consumer accepts result
//
// Output stage FSM
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_EMPTY | no result held, out_valid = 0
//   S_FULL  | result held, out_valid = 1; replaced on same-cycle accept
// ---------------------------------------------------------------------------

// Plain 64-bit adder with carry-out and two's-complement overflow.
module full_adder_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        overflow
);
    logic [64:0] sum_full;

    assign sum_full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    assign sum      = sum_full[63:0];
    assign cout     = sum_full[64];
    // Overflow when both operands share a sign and the sum's sign differs.
    assign overflow = (a[63] == b[63]) && (sum_full[63] != a[63]);
endmodule

module accumulator_64bit #(
    parameter logic SAT_DEFAULT = 1'b0,
    parameter int   CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [63:0]      in_data,
    input  logic             in_cin,
    input  logic             sat_en,
    input  logic             sticky_clr,
    output logic [63:0]      acc_out,
    output logic             cout_flag,
    output logic             ovf_flag,
    output logic             sat_flag,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [63:0] SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAT_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      acc_q, acc_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_mode_q, sat_mode_d;

    op_e              op;
    logic             accept;
    logic [63:0]      add_b;
    logic             add_cin;
    logic [63:0]      add_sum;
    logic             add_cout;
    logic             add_ovf;

    assign op     = op_e'(in_op);
    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Output-stage FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (state_q)
            S_EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
                if (accept) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                out_valid = 1'b1;
                // A same-cycle drain and accept keeps the stage full with
                // the new result, so there is no bubble under continuous flow.
                in_ready  = out_ready;
                if (out_ready && !accept) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Adder operand selection: SUB is acc + ~data + 1.
    // ------------------------------------------------------------------
    always_comb begin
        add_b   = in_data;
        add_cin = in_cin;
        if (op == OP_SUB) begin
            add_b   = ~in_data;
            add_cin = 1'b1;
        end
    end

    full_adder_64bit u_adder (
        .a        (acc_q),
        .b        (add_b),
        .cin      (add_cin),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    // ------------------------------------------------------------------
    // Commit logic: every field updates on the same accepting edge.
    // ------------------------------------------------------------------
    always_comb begin
        acc_d      = acc_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        sat_d      = sat_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        sat_mode_d = sat_mode_q;

        if (sticky_clr) begin
            sticky_d = 1'b0;
        end

        if (accept) begin
            cnt_d      = cnt_q + CNT_W'(1);
            sat_mode_d = sat_en;
            case (op)
                OP_ADD, OP_SUB: begin
                    cout_d = add_cout;
                    ovf_d  = add_ovf;
                    if (add_ovf) begin
                        // Overflow sets sticky even if sticky_clr is high.
                        sticky_d = 1'b1;
                    end
                    if (sat_mode_d && add_ovf) begin
                        // Overflow implies the true result has the sign of
                        // the old accumulator, so it picks the clamp direction.
                        acc_d = acc_q[63] ? SAT_MIN : SAT_MAX;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = add_sum;
                        sat_d = 1'b0;
                    end
                end
                OP_LOAD: begin
                    acc_d  = in_data;
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                    sat_d  = 1'b0;
                end
                OP_CLEAR: begin
                    acc_d    = 64'd0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    sat_d    = 1'b0;
                    sticky_d = 1'b0;
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= 64'd0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            sat_mode_q <= SAT_DEFAULT;
        end else begin
            acc_q      <= acc_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
            sat_mode_q <= sat_mode_d;
        end
    end

    assign acc_out    = acc_q;
    assign cout_flag  = cout_q;
    assign ovf_flag   = ovf_q;
    assign sat_flag   = sat_q;
    assign sticky_ovf = sticky_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_accumulator_64bit.sv
module tb_accumulator_64bit;

    localparam int CNT_W = 16;

    localparam logic [1:0] ADD   = 2'b00;
    localparam logic [1:0] SUB   = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [63:0]      in_data;
    logic             in_cin;
    logic             sat_en;
    logic             sticky_clr;
    logic [63:0]      acc_out;
    logic             cout_flag;
    logic             ovf_flag;
    logic             sat_flag;
    logic             sticky_ovf;
    logic [CNT_W-1:0] op_count;
    logic             out_valid;
    logic             out_ready;

    accumulator_64bit #(.SAT_DEFAULT(1'b0), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_cin     (in_cin),
        .sat_en     (sat_en),
        .sticky_clr (sticky_clr),
        .acc_out    (acc_out),
        .cout_flag  (cout_flag),
        .ovf_flag   (ovf_flag),
        .sat_flag   (sat_flag),
        .sticky_ovf (sticky_ovf),
        .op_count   (op_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0]      m_acc;
    logic             m_cout, m_ovf, m_sat, m_sticky, m_valid;
    logic [CNT_W-1:0] m_cnt;
    bit               model_known = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check in_ready, clock, update model, check outputs.
    task automatic step(input logic v, input logic [1:0] op, input logic [63:0] d,
                        input logic ci, input logic se, input logic sc,
                        input logic ordy, input logic r);
        logic                   acc_ok;
        logic signed [65:0]     ra, rd, r_true;
        logic [64:0]            u;
        logic                   ovf;
        in_valid   = v;
        in_op      = op;
        in_data    = d;
        in_cin     = ci;
        sat_en     = se;
        sticky_clr = sc;
        out_ready  = ordy;
        rst        = r;
        #2;
        if (model_known) chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || ordy)});
        acc_ok = model_known && v && (!m_valid || ordy) && !r;
        @(posedge clk);
        if (r) begin
            m_acc = '0; m_cout = 0; m_ovf = 0; m_sat = 0; m_sticky = 0;
            m_cnt = '0; m_valid = 0;
            model_known = 1;
        end else if (model_known) begin
            if (sc) m_sticky = 0;
            if (acc_ok) begin
                m_cnt   = m_cnt + 1'b1;
                m_valid = 1;
                case (op)
                    ADD, SUB: begin
                        ra = $signed({{2{m_acc[63]}}, m_acc});
                        rd = $signed({{2{d[63]}}, d});
                        if (op == ADD) begin
                            r_true = ra + rd + $signed({65'd0, ci});
                            u      = {1'b0, m_acc} + {1'b0, d} + {64'd0, ci};
                            m_cout = u[64];
                        end else begin
                            r_true = ra - rd;
                            m_cout = (m_acc >= d);
                        end
                        ovf   = (r_true > SMAX) || (r_true < SMIN);
                        m_ovf = ovf;
                        if (ovf) m_sticky = 1;
                        if (ovf && se) begin
                            m_acc = (r_true < 0) ? 64'h8000_0000_0000_0000
                                                 : 64'h7FFF_FFFF_FFFF_FFFF;
                            m_sat = 1;
                        end else begin
                            m_acc = r_true[63:0];
                            m_sat = 0;
                        end
                    end
                    LOAD: begin
                        m_acc = d; m_cout = 0; m_ovf = 0; m_sat = 0;
                    end
                    default: begin
                        m_acc = '0; m_cout = 0; m_ovf = 0; m_sat = 0; m_sticky = 0;
                    end
                endcase
            end else if (ordy) begin
                m_valid = 0;
            end
        end
        #1;
        if (model_known) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            chk("acc_out", acc_out, m_acc);
            chk("flags{cout,ovf,sat,sticky}",
                {60'd0, cout_flag, ovf_flag, sat_flag, sticky_ovf},
                {60'd0, m_cout, m_ovf, m_sat, m_sticky});
            chk("op_count", {48'd0, op_count}, {48'd0, m_cnt});
        end
    endtask

    // Directed expectations from the plan, independent of the model.
    task automatic expect_acc(input string tag, input logic [63:0] a,
                              input logic [3:0] flags);
        chk({tag, "_acc"}, acc_out, a);
        chk({tag, "_flags"}, {60'd0, cout_flag, ovf_flag, sat_flag, sticky_ovf},
            {60'd0, flags});
    endtask

    function automatic logic [63:0] rand_data();
        logic [63:0] pick [6];
        pick[0] = 64'h7FFF_FFFF_FFFF_FFFF;
        pick[1] = 64'h8000_0000_0000_0000;
        pick[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        pick[3] = 64'd0;
        pick[4] = 64'd1;
        pick[5] = 64'h4000_0000_0000_0000;
        if ($urandom_range(0, 3) == 0) return pick[$urandom_range(0, 5)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] held;
        in_valid = 0; in_op = ADD; in_data = '0; in_cin = 0; sat_en = 0;
        sticky_clr = 0; out_ready = 1; rst = 1;
        #1;
        step(0, ADD, 0, 0, 0, 0, 1, 1);
        step(0, ADD, 0, 0, 0, 0, 1, 1);
        chk("reset_op_count", {48'd0, op_count}, 64'd0);
        step(0, ADD, 0, 0, 0, 0, 1, 0);

        // 5 + 1 + 10
        step(1, ADD, 64'h5, 1, 0, 0, 1, 0);
        step(1, ADD, 64'hA, 0, 0, 0, 1, 0);
        expect_acc("add_basic", 64'h10, 4'b0000);
        chk("add_basic_cnt", {48'd0, op_count}, 64'd2);

        // Signed overflow, no saturation then with saturation
        step(1, LOAD, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0);
        step(1, ADD, 64'h1, 0, 0, 0, 1, 0);
        expect_acc("ovf_nosat", 64'h8000_0000_0000_0000, 4'b0101);
        step(1, LOAD, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0, 1, 0);
        step(1, ADD, 64'h1, 0, 1, 0, 1, 0);
        expect_acc("ovf_sat", 64'h7FFF_FFFF_FFFF_FFFF, 4'b0111);

        // Unsigned carry, then borrow
        step(1, CLEAR, 0, 0, 0, 0, 1, 0);
        step(1, LOAD, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0);
        step(1, ADD, 64'h1, 0, 0, 0, 1, 0);
        expect_acc("carry", 64'h0, 4'b1000);
        step(1, SUB, 64'h1, 0, 0, 0, 1, 0);
        expect_acc("borrow", 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000);

        // Backpressure: held output stays stable, nothing accepted
        held = acc_out;
        for (int i = 0; i < 3; i++) begin
            step(1, ADD, 64'h3, 0, 0, 0, 0, 0);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_acc_stable", acc_out, held);
        end
        for (int i = 0; i < 4; i++) step(1, ADD, 64'h3, 0, 0, 0, 1, 0);
        chk("bp_release_acc", acc_out, held + 64'd12);

        // Sticky set beats clear; then clear alone
        step(1, LOAD, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0);
        step(1, ADD, 64'h1, 0, 0, 1, 1, 0);
        chk("sticky_set_wins", {63'd0, sticky_ovf}, 64'd1);
        step(0, ADD, 0, 0, 0, 1, 1, 0);
        chk("sticky_clr", {63'd0, sticky_ovf}, 64'd0);

        // Reset while full
        step(1, LOAD, 64'h1234, 0, 0, 0, 0, 0);
        step(1, ADD, 64'h1, 0, 0, 0, 0, 1);
        expect_acc("rst_full", 64'd0, 4'b0000);
        chk("rst_full_valid", {63'd0, out_valid}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) op = CLEAR;
            step($urandom_range(0, 3) != 0, op, rand_data(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/accumulator_64bit.md
# accumulator_64bit

Registered 64-bit signed/unsigned accumulator that sits directly downstream of `full_adder_64bit` and consumes its `sum`, `cout` and `overflow` outputs. Each accepted command feeds the current accumulator value and an input operand into one internal `full_adder_64bit` instance. It commits the result with optional signed saturation and presents it, with flags, through a valid/ready output stage. The block is the first stateful consumer of the adder in the arithmetic path.

## Interface
- `SAT_DEFAULT`, 0: reset value of the internal saturation-enable register.
- `CNT_W`, 16: width of the accepted-operation counter.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command/operand valid.
- `in_ready`  out  1  block can accept a command this cycle.
- `in_op`  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- `in_data`  in  64  operand.
- `in_cin`  in  1  carry-in for ADD; ignored otherwise.
- `sat_en`  in  1  sampled on every accepted command; 1 = signed saturation on overflow.
- `sticky_clr`  in  1  clears `sticky_ovf` (accept-independent).
- `acc_out`  out  64  committed accumulator value.
- `cout_flag`  out  1  adder `cout` of the last accepted command.
- `ovf_flag`  out  1  adder `overflow` of the last accepted command.
- `sat_flag`  out  1  last result was saturated.
- `sticky_ovf`  out  1  set by any overflow since the last clear.
- `op_count`  out  CNT_W  number of accepted commands, wrapping.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer accepts result.

## Operation
- Handshake: a command is accepted when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, which gives single-entry output buffering with no bubble under continuous flow.
- The output FSM has two states. EMPTY (`out_valid`=0) goes to FULL on accept. FULL goes to EMPTY on `out_ready` without a new accept. FULL stays FULL when `out_ready` and an accept occur in the same cycle, and the new result replaces the old one.
- Adder wiring: `a = acc`.
  - ADD: `b = in_data`, `cin = in_cin`.
  - SUB: `b = ~in_data`, `cin = 1` (two's complement; `cout`=1 means no borrow).
- ADD/SUB commit: `acc <= sum`, `cout_flag <= cout`, `ovf_flag <= overflow`.
  - If `sat_en` and `overflow`: when `acc[63]`=0, `acc <= 64'h7FFF_FFFF_FFFF_FFFF`; otherwise `acc <= 64'h8000_0000_0000_0000`. `sat_flag <= 1`.
  - Otherwise `sat_flag <= 0`.
- LOAD: `acc <= in_data`. `cout_flag`, `ovf_flag` and `sat_flag` are all set to 0.
- CLEAR: `acc <= 0`. All flags are set to 0, including `sticky_ovf`.
- `sticky_ovf` is set by the `overflow` of any accepted ADD/SUB, whether or not the result saturated.
  - `sticky_clr` clears it.
  - If `sticky_clr` and a new overflow occur in the same cycle, the set wins.
- `op_count` increments on every accept, including LOAD and CLEAR. It wraps from `2^CNT_W-1` to 0.
- `acc_out` and the flags hold their value while `out_valid`=0. They change only on accept.

## Timing
- Latency is 1 cycle: a command accepted at edge N appears on `acc_out`/flags with `out_valid`=1 after edge N.
- Throughput is 1 command/cycle while `out_ready`=1.
- Backpressure: when FULL and `out_ready`=0, `in_ready` is 0 and `acc_out` and the flags are stable.
- Reset values: `acc_out`=0, `cout_flag`=0, `ovf_flag`=0, `sat_flag`=0, `sticky_ovf`=0, `op_count`=0, `out_valid`=0.
  - `in_ready`=1 in the cycle after reset deasserts.
  - Saturation register = `SAT_DEFAULT`.
- Reset asserted mid-stream discards any pending output and the in-flight command with no partial update. Reset dominates all other inputs.
- All flag and accumulator updates occur together in one edge; they are never split across cycles.

## Test plan
- Reset, then ADD `in_data=64'h5`, `in_cin=1`, then ADD `64'hA`, `in_cin=0` -> `acc_out=64'h10`, `op_count=2`, all flags 0.
- LOAD `64'h7FFF_FFFF_FFFF_FFFF`, ADD `1`, `sat_en=0` -> `acc_out=64'h8000_0000_0000_0000`, `ovf_flag=1`, `sticky_ovf=1`, `sat_flag=0`.
  - Repeat with `sat_en=1` -> `acc_out=64'h7FFF_FFFF_FFFF_FFFF`, `sat_flag=1`.
- LOAD `64'hFFFF_FFFF_FFFF_FFFF`, ADD `1` -> `acc_out=0`, `cout_flag=1`, `ovf_flag=0`.
  - SUB `1` from 0 -> `acc_out=64'hFFFF_FFFF_FFFF_FFFF`, `cout_flag=0`.
- Hold `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0` and `acc_out` stable.
  - Release -> commands accepted back-to-back, one per cycle, and no command is lost or duplicated.
- Assert `sticky_clr` in the same cycle as an overflowing ADD -> `sticky_ovf` stays 1.
  - Next cycle, `sticky_clr` alone -> `sticky_ovf=0`.
  - Assert `rst` while FULL -> all outputs return to their reset values after one edge.
